modular_inverse: RTL and testbench

Computes the modular multiplicative inverse d = e⁻¹ mod m with an iterative extended Euclidean algorithm. It uses a bit-serial restoring divider and a bit-serial double-and-add modular multiplier. It is the key-generation counterpart of the modular exponentiation engine: it derives the private exponent d from the public exponent e and φ(n), and hands d to the exponentiation block for decryption. It uses the same ready/busy/valid handshake as the other arithmetic blocks, so a top-level FSM can chain it directly.

---
 rtl/modular_inverse.sv | 190 +++++++++++++++++++
 tb/tb_modular_inverse.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/modular_inverse.sv
// Modular inverse d = e^-1 mod m via iterative extended Euclid, using a
// bit-serial restoring divider and a bit-serial double-and-add modular multiplier.
module modular_inverse #(
  parameter int KEY_BYTES = 4,
  localparam int W = 8 * KEY_BYTES
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         ready_in,
  input  logic [W-1:0] value_in,
  input  logic [W-1:0] modulus_in,
  output logic [W-1:0] value_out,
  output logic         error_out,
  output logic         busy_out,
  output logic         valid_out
);

  localparam int CW = $clog2(W);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DIV,
    MUL,
    UPDATE,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  r0_q, r0_d, r1_q, r1_d;
  logic [W-1:0]  t0_q, t0_d, t1_q, t1_d;
  logic [W-1:0]  m_q, m_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W:0]    rem_q, rem_d;
  logic [W:0]    acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bad_q, bad_d;
  logic [W-1:0]  value_q, value_d;
  logic          error_q, error_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;

  logic [W:0]    trial;
  logic [W:0]    dbl, dblRed;
  logic [W:0]    sum, sumRed;
  logic [W:0]    diff;
  logic          lastBit;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      r0_q    <= '0;
      r1_q    <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      m_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      value_q <= '0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      m_q     <= m_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      value_q <= value_d;
      error_q <= error_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    m_d     = m_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    value_d = value_q;
    error_d = error_q;
    busy_d  = busy_q;
    valid_d = 1'b0;

    lastBit = (cnt_q == CW'(W - 1));

    // The dividend is shifted out of quo_q while quotient bits shift in behind it.
    trial = (rem_q << 1) | {{W{1'b0}}, quo_q[W-1]};

    // acc and t1 are both below m, so one conditional subtract per step suffices.
    dbl    = acc_q << 1;
    dblRed = (dbl >= {1'b0, m_q}) ? dbl - {1'b0, m_q} : dbl;
    sum    = dblRed + {1'b0, t1_q};
    sumRed = (sum >= {1'b0, m_q}) ? sum - {1'b0, m_q} : sum;

    diff = {1'b0, t0_q} - acc_q;

    case (state_q)
      IDLE: begin
        if (ready_in) begin
          r0_d    = modulus_in;
          r1_d    = value_in;
          t0_d    = '0;
          t1_d    = W'(1);
          m_d     = modulus_in;
          bad_d   = (modulus_in < W'(2)) || (value_in == '0);
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (bad_q || (r1_q == '0)) begin
          state_d = DONE;
        end else begin
          quo_d   = r0_q;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        if (trial >= {1'b0, r1_q}) begin
          rem_d = trial - {1'b0, r1_q};
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = trial;
          quo_d = {quo_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (lastBit) begin
          cnt_d   = '0;
          acc_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = quo_q[W-1] ? sumRed : dblRed;
        quo_d = {quo_q[W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (lastBit) begin
          cnt_d   = '0;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        r0_d    = r1_q;
        r1_d    = rem_q[W-1:0];
        t0_d    = t1_q;
        t1_d    = diff[W] ? diff[W-1:0] + m_q : diff[W-1:0];
        state_d = CHECK;
      end
      DONE: begin
        if (!bad_q && (r0_q == W'(1))) begin
          value_d = t0_q;
          error_d = 1'b0;
        end else begin
          value_d = '0;
          error_d = 1'b1;
        end
        busy_d  = 1'b0;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign value_out = value_q;
  assign error_out = error_q;
  assign busy_out  = busy_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_modular_inverse.sv
// Randomized self-checking bench for modular_inverse against a plain
// integer extended-Euclid reference model, including result latency.
module tb_modular_inverse;

  localparam int W    = 32;
  localparam int ITER = 2 * W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         ready;
  logic [W-1:0] valueIn;
  logic [W-1:0] modulusIn;
  logic [W-1:0] valueOut;
  logic         errorOut;
  logic         busyOut;
  logic         validOut;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  modular_inverse #(.KEY_BYTES(4)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .ready_in  (ready),
    .value_in  (valueIn),
    .modulus_in(modulusIn),
    .value_out (valueOut),
    .error_out (errorOut),
    .busy_out  (busyOut),
    .valid_out (validOut)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Textbook extended Euclid on signed integers; also reports the iteration count.
  task automatic refModel(input longint e, input longint m, output longint d,
                          output bit err, output int n);
    longint r0, r1, t0, t1, q, tmp;
    n = 0;
    d = 0;
    err = 1'b1;
    if (m < 2 || e == 0) return;
    r0 = m;
    r1 = e;
    t0 = 0;
    t1 = 1;
    while (r1 != 0) begin
      q   = r0 / r1;
      tmp = r0 - q * r1;
      r0  = r1;
      r1  = tmp;
      tmp = t0 - q * t1;
      t0  = t1;
      t1  = tmp;
      n++;
    end
    if (r0 == 1) begin
      err = 1'b0;
      d   = ((t0 % m) + m) % m;
    end
  endtask

  task automatic applyStimulus(input string tag, input longint e, input longint m,
                               input bit chained, input bit injectBusy);
    longint expD;
    bit     expErr;
    int     expN;
    int     edges;
    bit     seen;
    refModel(e, m, expD, expErr, expN);
    if (!chained) @(negedge clk);
    ready     = 1'b1;
    valueIn   = W'(e);
    modulusIn = W'(m);
    @(posedge clk);
    #1;
    ready     = 1'b0;
    valueIn   = $urandom;
    modulusIn = $urandom;
    checkOutput({tag, "/busyStart"}, 64'(busyOut), 64'd1);
    edges = 0;
    seen  = 1'b0;
    while (edges < 4000 && !seen) begin
      if (injectBusy && edges == 10) begin
        ready     = 1'b1;
        valueIn   = $urandom;
        modulusIn = $urandom | 32'd2;
      end
      @(posedge clk);
      #1;
      edges++;
      ready = 1'b0;
      if (validOut) seen = 1'b1;
    end
    checkOutput({tag, "/latency"}, 64'(edges), 64'(2 + expN * ITER));
    checkOutput({tag, "/value"}, 64'(valueOut), 64'(expD));
    checkOutput({tag, "/error"}, 64'(errorOut), 64'(expErr));
    checkOutput({tag, "/busyEnd"}, 64'(busyOut), 64'd0);
  endtask

  initial begin
    int  sawValid;
    logic [W-1:0] heldValue;
    longint e, m, f;
    int mode;

    rst       = 1'b1;
    ready     = 1'b0;
    valueIn   = '0;
    modulusIn = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset/value", 64'(valueOut), 64'd0);
    checkOutput("reset/error", 64'(errorOut), 64'd0);
    checkOutput("reset/busy", 64'(busyOut), 64'd0);
    checkOutput("reset/valid", 64'(validOut), 64'd0);
    rst = 1'b0;

    applyStimulus("e3m20", 3, 20, 1'b0, 1'b0);
    checkOutput("e3m20/seven", 64'(valueOut), 64'd7);
    applyStimulus("e65537m3120", 65537, 3120, 1'b0, 1'b0);
    checkOutput("e65537m3120/product", (64'd65537 * 64'(valueOut)) % 64'd3120, 64'd1);
    applyStimulus("e4m20", 4, 20, 1'b0, 1'b0);
    applyStimulus("e0m20", 0, 20, 1'b0, 1'b0);
    applyStimulus("e5m1", 5, 1, 1'b0, 1'b0);
    applyStimulus("e5m0", 5, 0, 1'b0, 1'b0);
    applyStimulus("e23m7", 23, 7, 1'b0, 1'b0);
    checkOutput("e23m7/four", 64'(valueOut), 64'd4);
    heldValue = valueOut;
    @(posedge clk);
    #1;
    checkOutput("pulse/validLow", 64'(validOut), 64'd0);
    checkOutput("pulse/valueHeld", 64'(valueOut), 64'(heldValue));

    applyStimulus("busyIgnore", 17, 3120, 1'b0, 1'b1);
    applyStimulus("b2bFirst", 3, 20, 1'b0, 1'b0);
    applyStimulus("b2bSecond", 23, 7, 1'b1, 1'b0);

    @(negedge clk);
    ready     = 1'b1;
    valueIn   = 32'd3;
    modulusIn = 32'd20;
    @(posedge clk);
    #1;
    ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort/value", 64'(valueOut), 64'd0);
    checkOutput("abort/error", 64'(errorOut), 64'd0);
    checkOutput("abort/busy", 64'(busyOut), 64'd0);
    checkOutput("abort/valid", 64'(validOut), 64'd0);
    rst = 1'b0;
    sawValid = 0;
    repeat (250) begin
      @(posedge clk);
      #1;
      if (validOut) sawValid++;
    end
    checkOutput("abort/noPulse", 64'(sawValid), 64'd0);
    applyStimulus("afterAbort", 3, 20, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin
          e = longint'($urandom);
          m = longint'($urandom);
          if (m < 2) m = m + 2;
        end
        1: begin
          e = $urandom_range(0, 1000);
          m = $urandom_range(2, 1000);
        end
        2: begin
          f = $urandom_range(2, 50);
          e = f * $urandom_range(1, 20000);
          m = f * $urandom_range(1, 20000);
        end
        default: begin
          e = longint'($urandom);
          m = $urandom_range(2, 5000);
        end
      endcase
      applyStimulus($sformatf("rand%0d", i), e, m, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
